sram_port_arbiter: RTL

Round-robin arbiter that shares the single SRAM read/write port among the CNN solver's five datapath clients: quadrant engines 0–3 and the step-2 engine. It replaces fixed, state-selected muxing with a request/grant handshake, so clients may contend for the port. It bounds each client's tenure with a burst limit and inserts a turnaround cycle after writes. It sits between the client modules and the SRAM wrapper in the top-level design.

---
 rtl/sram_port_arbiter_pkg.sv | 23 ++
 rtl/sram_port_arbiter_if.sv | 33 +++
 rtl/sram_port_arbiter_rr_pick.sv | 34 +++
 rtl/sram_port_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter and its clients.
// Latency: none, declarations only.
// Backpressure: not applicable.
package cnn_arb_pkg;

    localparam int N_REQ  = 5;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    // Client slots on the arbiter request vector
    localparam int QUAD0 = 0;
    localparam int QUAD1 = 1;
    localparam int QUAD2 = 2;
    localparam int QUAD3 = 3;
    localparam int STEP2 = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Client request/grant bundle plus the muxed SRAM port, shared by the arbiter and its clients.
// Latency: wires only.
// Backpressure: clients hold req until gnt arrives; gnt is the only throttle.
interface sram_port_arbiter_if;
    import cnn_arb_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] rd_addr;
    logic [N_REQ*ADDR_W-1:0] wr_addr;
    logic [N_REQ*DATA_W-1:0] wr_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rd_valid;
    logic [ADDR_W-1:0]       sram_rd_addr;
    logic                    sram_wr_en;
    logic [ADDR_W-1:0]       sram_wr_addr;
    logic [DATA_W-1:0]       sram_wr_data;
    logic                    busy;

    // Client side: drives requests and access fields, observes grant/valid
    modport master (
        output req, lock, we, rd_addr, wr_addr, wr_data,
        input  gnt, rd_valid, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, busy
    );

    // Arbiter side
    modport slave (
        input  req, lock, we, rd_addr, wr_addr, wr_data,
        output gnt, rd_valid, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, busy
    );

endinterface

// File: rtl/sram_port_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after last_i, searching cyclically.
// Latency: combinational.
// Backpressure: none; pick_o is zero when no request is present.
module rr_pick
    import cnn_arb_pkg::*;
#(
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [IDX_W-1:0] pick_idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk last+1 .. last+N_REQ so the previous owner is considered last
    always_comb begin
        pick_o     = '0;
        pick_idx_o = '0;
        found      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                pick_o[cand] = 1'b1;
                pick_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin owner of the single SRAM port with burst limit and post-write turnaround.
// Latency: req in IDLE at edge k -> gnt and first access in cycle k+1; rd_valid one cycle after a read.
// Backpressure: non-owners hold req and wait; tenure ends on lock drop, req drop or MAX_BURST cycles.
module sram_port_arbiter
    import cnn_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    sram_port_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             acc_vld;
    logic             wr_seen;
    logic             rel;

    logic [ADDR_W-1:0] rd_addr_mux;
    logic [ADDR_W-1:0] wr_addr_mux;
    logic [DATA_W-1:0] wr_data_mux;
    logic              wr_en_mux;

    rr_pick #(.IDX_W(IDX_W)) u_pick (
        .req_i      (bus.req),
        .last_i     (last_owner_q),
        .pick_o     (pick),
        .pick_idx_o (pick_idx)
    );

    // gnt is one-hot or zero, so masking with it isolates the owner's bits
    assign acc_vld = |(gnt_q & bus.req);
    assign wr_seen = |(gnt_q & bus.req & bus.we);

    // Forward only the owner's access, and only while it is requesting
    always_comb begin
        rd_addr_mux = '0;
        wr_addr_mux = '0;
        wr_data_mux = '0;
        wr_en_mux   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i] && bus.req[i]) begin
                if (bus.we[i]) begin
                    wr_en_mux   = 1'b1;
                    wr_addr_mux = bus.wr_addr[i*ADDR_W +: ADDR_W];
                    wr_data_mux = bus.wr_data[i*DATA_W +: DATA_W];
                end else begin
                    rd_addr_mux = bus.rd_addr[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // Next-state: arbitrate only in IDLE, count tenure in OWN, one dead cycle in TURN
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        rel          = 1'b0;
        rd_valid_d   = gnt_q & bus.req & ~bus.we;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|bus.req) begin
                    gnt_d        = pick;
                    last_owner_d = pick_idx;
                    burst_cnt_d  = '0;
                    state_d      = OWN;
                end
            end
            OWN: begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
                rel = !(|(gnt_q & bus.lock)) || !acc_vld ||
                      (burst_cnt_q == CNT_W'(MAX_BURST - 1));
                if (rel) begin
                    gnt_d   = '0;
                    state_d = wr_seen ? TURN : IDLE;
                end
            end
            TURN: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight rd_valid and pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            rd_valid_q   <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rd_valid_q   <= rd_valid_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.sram_rd_addr = rd_addr_mux;
    assign bus.sram_wr_en   = wr_en_mux;
    assign bus.sram_wr_addr = wr_addr_mux;
    assign bus.sram_wr_data = wr_data_mux;

endmodule
